// File: rtl/led_sequencer.sv
// LED pattern sequencer: holds the LEDs dark for a startup delay, then steps one of
// four patterns (wipe, rotate, bounce, fill) once every STEP_CYCLES enabled clocks.
module led_sequencer #(
    parameter int NUM_LEDS       = 4,
    parameter int STARTUP_CYCLES = 12000000,
    parameter int STEP_CYCLES    = 1200000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                not_ready_led,
    output logic                ready,
    output logic                step
);

    typedef enum logic [1:0] {
        MODE_WIPE   = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    localparam int CNT_W  = $clog2(STARTUP_CYCLES) + 1;
    localparam int DIV_W  = $clog2(STEP_CYCLES) + 1;
    localparam int POS_W  = $clog2(NUM_LEDS + 2) + 1;
    localparam int WIDE_W = NUM_LEDS + 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] POS_FILL = POS_W'(NUM_LEDS);
    localparam logic [POS_W-1:0] POS_WIPE = POS_W'(NUM_LEDS + 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic             DIR_UP   = 1'b0;
    localparam logic             DIR_DOWN = 1'b1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    mode_e               mode_q, mode_d;
    logic                step_q, step_d;

    logic [POS_W-1:0]    pos_eff;
    logic                dir_eff;
    logic [WIDE_W-1:0]   wide;
    logic                fire;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        div_d     = div_q;
        pattern_d = pattern_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        step_d    = 1'b0;
        pos_eff   = pos_q;
        dir_eff   = dir_q;
        wide      = '0;
        fire      = 1'b0;

        if (!ready_q) begin
            cnt_d   = cnt_q + 1'b1;
            ready_d = (cnt_q == CNT_LAST);
            div_d   = '0;
        end else if (enable) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                fire  = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (fire) begin
            step_d = 1'b1;
            // A new mode always starts from its first pattern, moving up.
            if (mode_e'(mode) != mode_q) begin
                mode_d  = mode_e'(mode);
                pos_eff = '0;
                dir_eff = DIR_UP;
                dir_d   = DIR_UP;
            end
            unique case (mode_d)
                MODE_WIPE: begin
                    wide  = (WIDE_W'(3) << pos_eff) >> 1;
                    pos_d = (pos_eff == POS_WIPE) ? '0 : pos_eff + 1'b1;
                end
                MODE_ROTATE: begin
                    wide  = WIDE_W'(1) << pos_eff;
                    pos_d = (pos_eff == POS_TOP) ? '0 : pos_eff + 1'b1;
                end
                MODE_BOUNCE: begin
                    wide = WIDE_W'(1) << pos_eff;
                    if (dir_eff == DIR_UP) begin
                        dir_d = (pos_eff == POS_TOP) ? DIR_DOWN : DIR_UP;
                        pos_d = (pos_eff == POS_TOP) ? pos_eff - 1'b1 : pos_eff + 1'b1;
                    end else begin
                        dir_d = (pos_eff == '0) ? DIR_UP : DIR_DOWN;
                        pos_d = (pos_eff == '0) ? POS_ONE : pos_eff - 1'b1;
                    end
                end
                MODE_FILL: begin
                    wide  = (pos_eff == POS_FILL) ? '0
                          : (WIDE_W'(1) << (pos_eff + POS_ONE)) - WIDE_W'(1);
                    pos_d = (pos_eff == POS_FILL) ? '0 : pos_eff + 1'b1;
                end
            endcase
            pattern_d = wide[NUM_LEDS-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            div_q     <= '0;
            pattern_q <= '0;
            pos_q     <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_WIPE;
            step_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            div_q     <= div_d;
            pattern_q <= pattern_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            step_q    <= step_d;
        end
    end

    assign leds          = ready_q ? pattern_q : '0;
    assign not_ready_led = ~ready_q;
    assign ready         = ready_q;
    assign step          = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomised and directed bench for led_sequencer; a pattern-table reference model
// predicts ready, step and leds every cycle.
module tb_led_sequencer;

    localparam int N  = 4;
    localparam int SC = 10;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   mode;
    logic [N-1:0] leds;
    logic         not_ready_led;
    logic         ready;
    logic         step;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_sequencer #(
        .NUM_LEDS      (N),
        .STARTUP_CYCLES(SC),
        .STEP_CYCLES   (ST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .leds         (leds),
        .not_ready_led(not_ready_led),
        .ready        (ready),
        .step         (step)
    );

    // Reference model: elapsed startup count, enabled-cycle count, index into a pattern table.
    int           m_cnt, m_ec, m_idx, m_mode;
    bit           m_ready, m_step;
    logic [N-1:0] m_pat;

    function automatic int seq_len(int m);
        case (m)
            0:       return N + 2;
            1:       return N;
            2:       return 2 * N - 2;
            default: return N + 1;
        endcase
    endfunction

    function automatic logic [N-1:0] seq_pat(int m, int i);
        logic [N-1:0] p;
        int hot;
        p   = '0;
        hot = (i < N) ? i : 2 * N - 2 - i;
        for (int b = 0; b < N; b++) begin
            case (m)
                0:       p[b] = (b == i) || (b == i - 1);
                1:       p[b] = (b == i);
                2:       p[b] = (b == hot);
                default: p[b] = (i < N) && (b <= i);
            endcase
        end
        return p;
    endfunction

    function automatic logic [N+2:0] exp_vec();
        return {m_ready, ~m_ready, m_step, (m_ready ? m_pat : {N{1'b0}})};
    endfunction

    function automatic logic [N+2:0] obs_vec();
        return {ready, not_ready_led, step, leds};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_cnt = 0; m_ready = 0; m_ec = 0; m_pat = '0;
            m_mode = 0; m_idx = 0; m_step = 0;
        end else begin
            m_step = 0;
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == SC) m_ready = 1;
            end else if (enable) begin
                m_ec++;
                if (m_ec % ST == 0) begin
                    m_step = 1;
                    if (int'(mode) != m_mode) begin
                        m_mode = int'(mode);
                        m_idx  = 0;
                    end
                    m_pat = seq_pat(m_mode, m_idx);
                    m_idx = (m_idx + 1) % seq_len(m_mode);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; mode = 2'd0;
        tick(); tick();
        total++;
        if (obs_vec() !== 7'b0100000) begin
            bad++; $display("FAIL reset_state: got %b want %b", obs_vec(), 7'b0100000);
        end
        reset = 1'b0;
        for (int i = 1; i <= SC; i++) begin
            tick();
            total++;
            if (ready !== (i == SC) || not_ready_led !== (i != SC) || leds !== '0) begin
                bad++; $display("FAIL startup_edge%0d: got rdy=%b nrl=%b leds=%b want rdy=%b",
                                i, ready, not_ready_led, leds, (i == SC));
            end
        end
    endtask

    task automatic test_pattern(input string name, input logic [1:0] m,
                                input logic [8*N-1:0] want, input int cnt);
        mode = m;
        for (int s = 0; s < cnt; s++) begin
            for (int c = 1; c <= ST; c++) begin
                tick();
                total++;
                if (obs_vec() !== exp_vec()) begin
                    bad++; $display("FAIL %s_model s%0d c%0d: got %b want %b",
                                    name, s, c, obs_vec(), exp_vec());
                end
            end
            total++;
            if (step !== 1'b1 || leds !== want[s*N +: N]) begin
                bad++; $display("FAIL %s_step%0d: got step=%b leds=%b want step=1 leds=%b",
                                name, s, step, leds, want[s*N +: N]);
            end
        end
    endtask

    task automatic test_pause();
        logic [N-1:0] held;
        tick(); tick();
        enable = 1'b0;
        held   = leds;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (leds !== held || step !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL pause_hold%0d: got leds=%b step=%b want leds=%b step=0",
                                i, leds, step, held);
            end
        end
        enable = 1'b1;
        tick();
        total++;
        if (step !== 1'b0 || leds !== held) begin
            bad++; $display("FAIL pause_resume1: got step=%b leds=%b want step=0 leds=%b",
                            step, leds, held);
        end
        tick();
        total++;
        if (step !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL pause_resume2: got %b want %b (step=1)", obs_vec(), exp_vec());
        end
    endtask

    task automatic wait_leds(input string name, input logic [N-1:0] target);
        int budget;
        budget = 300;
        while (!(step === 1'b1 && leds === target) && budget > 0) begin
            tick();
            budget--;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL %s_wait: got %b want %b", name, obs_vec(), exp_vec());
            end
        end
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got leds=%b want leds=%b", name, leds, target);
        end
    endtask

    task automatic test_mode_switch();
        logic [N-1:0] want [2];
        want[0] = 4'b0001; want[1] = 4'b0011;
        mode = 2'd1;
        wait_leds("switch", 4'b0100);
        mode = 2'd3;
        for (int s = 0; s < 2; s++) begin
            for (int c = 1; c <= ST; c++) tick();
            total++;
            if (step !== 1'b1 || leds !== want[s]) begin
                bad++; $display("FAIL switch_step%0d: got step=%b leds=%b want step=1 leds=%b",
                                s, step, leds, want[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'd0;
        wait_leds("midrst", 4'b1100);
        reset = 1'b1;
        tick();
        total++;
        if (leds !== 4'b0000 || ready !== 1'b0 || not_ready_led !== 1'b1) begin
            bad++; $display("FAIL midrst_state: got leds=%b rdy=%b nrl=%b want 0000/0/1",
                            leds, ready, not_ready_led);
        end
        reset = 1'b0;
        for (int i = 1; i <= SC; i++) begin
            tick();
            total++;
            if (ready !== (i == SC)) begin
                bad++; $display("FAIL midrst_startup%0d: got rdy=%b want %b", i, ready, (i == SC));
            end
        end
        for (int c = 1; c <= ST; c++) tick();
        total++;
        if (step !== 1'b1 || leds !== 4'b0001) begin
            bad++; $display("FAIL midrst_first: got step=%b leds=%b want step=1 leds=0001",
                            step, leds);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0);
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random_c%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pattern("wipe",   2'd0, 32'h0108C631, 7);
        test_pattern("rotate", 2'd1, 32'h00018421, 5);
        test_pattern("fill",   2'd3, 32'h0010F731, 6);
        test_pattern("bounce", 2'd2, 32'h21248421, 8);
        test_pause();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
